ifid_ctrl: RTL and testbench

Fetch-stage pipeline controller for the IF/ID latch. Each cycle it decides whether the PC advances, whether IF/ID loads, holds or is cleared to a bubble, and whether ID/EX takes a bubble. The decision uses instruction-memory handshake, data-memory busy, load-use hazard, EX-stage redirect and halt. It tracks one wrong-path fetch still outstanding after a redirect, latches halt, and keeps saturating stall and flush counters. It sits between the hazard/forwarding logic and the PC, IF/ID and ID/EX registers.

---
 rtl/ifid_ctrl.sv | 138 +++++++++++++
 tb/tb_ifid_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ifid_ctrl.sv
// IF/ID pipeline controller: decides PC advance and IF/ID / ID/EX load, hold or flush.
// It also tracks one outstanding wrong-path fetch, latches halt and keeps saturating counters.
module ifid_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dmem_busy,
    input  logic        load_use,
    input  logic        redirect,
    input  logic        halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        imemREN,
    output logic        squashing,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        flush_inc;

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        imemREN    = 1'b0;
        flush_inc  = 1'b0;

        if (RST) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = FETCH;
            halted_d   = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (halt) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        state_d    = HALTED;
                        halted_d   = 1'b1;
                    end else if (dmem_busy) begin
                        // whole pipe frozen: everything holds
                    end else if (redirect) begin
                        pc_en      = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        imemREN    = 1'b1;
                        flush_inc  = 1'b1;
                        if (!ihit) begin
                            state_d = SQUASH;
                        end
                    end else if (load_use) begin
                        idex_flush = 1'b1;
                        imemREN    = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                        imemREN    = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        imemREN = 1'b1;
                    end
                end
                SQUASH: begin
                    if (halt) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        state_d    = HALTED;
                        halted_d   = 1'b1;
                    end else begin
                        imemREN    = 1'b1;
                        ifid_flush = 1'b1;
                        // a new redirect keeps us waiting; otherwise the returning word ends the squash
                        if (redirect) begin
                            pc_en     = 1'b1;
                            flush_inc = 1'b1;
                        end else if (ihit) begin
                            state_d = FETCH;
                        end
                    end
                end
                default: begin
                    state_d = HALTED;
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (RST) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (state_q != HALTED && !pc_en && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (flush_inc && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= FETCH;
            halted_q    <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign squashing = (state_q == SQUASH);
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ifid_ctrl.sv
// Scoreboard bench for ifid_ctrl: a rule-level model predicts every cycle's outputs,
// a separate monitor pops and compares them on the falling edge.
module tb_ifid_ctrl;

    logic        CLK = 1'b0;
    logic        RST, ihit, dmem_busy, load_use, redirect, halt;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, imemREN, squashing, halted;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 CLK = ~CLK;

    ifid_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dmem_busy  (dmem_busy),
        .load_use   (load_use),
        .redirect   (redirect),
        .halt       (halt),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .imemREN    (imemREN),
        .squashing  (squashing),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    typedef struct packed {
        logic        pc_en;
        logic        ifid_en;
        logic        ifid_flush;
        logic        idex_flush;
        logic        imemREN;
        logic        squashing;
        logic        halted;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;

    // Reference model state: where the fetch stage is, as plain flags and integer counters.
    bit m_wait_wrong_path = 0;
    bit m_is_halted       = 0;
    int m_stalls          = 0;
    int m_flushes         = 0;

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    // Drive one cycle's inputs, predict the outputs, push the prediction, advance the model.
    task automatic step(input bit r, input bit ih, input bit db, input bit lu, input bit rd, input bit ht);
        obs_t e;
        bit   flush_event;
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dmem_busy = db; load_use = lu; redirect = rd; halt = ht;
        e = '0;
        e.squashing = m_wait_wrong_path;
        e.halted    = m_is_halted;
        e.stall_cnt = 16'(m_stalls);
        e.flush_cnt = 16'(m_flushes);
        flush_event = 0;
        if (r) begin
            e.ifid_flush = 1; e.idex_flush = 1;
            m_wait_wrong_path = 0; m_is_halted = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_is_halted) begin
            // frozen until reset
        end else begin
            if (ht) begin
                e.ifid_flush = 1; e.idex_flush = 1;
                m_is_halted = 1; m_wait_wrong_path = 0;
            end else if (m_wait_wrong_path) begin
                e.imemREN = 1; e.ifid_flush = 1;
                if (rd) begin
                    e.pc_en = 1; flush_event = 1;
                end else if (ih) begin
                    m_wait_wrong_path = 0;
                end
            end else if (db) begin
                // hold everything
            end else if (rd) begin
                e.pc_en = 1; e.ifid_flush = 1; e.idex_flush = 1; e.imemREN = 1;
                flush_event = 1;
                m_wait_wrong_path = !ih;
            end else if (lu) begin
                e.idex_flush = 1; e.imemREN = 1;
            end else if (!ih) begin
                e.ifid_flush = 1; e.imemREN = 1;
            end else begin
                e.pc_en = 1; e.ifid_en = 1; e.imemREN = 1;
            end
            if (!e.pc_en) m_stalls = sat_inc(m_stalls);
            if (flush_event) m_flushes = sat_inc(m_flushes);
        end
        exp_q.push_back(e);
        cycle++;
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_en, ifid_en, ifid_flush, idex_flush, imemREN, squashing, halted, stall_cnt, flush_cnt};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs @%0t: got pc_en=%b ifid_en=%b ifid_flush=%b idex_flush=%b imemREN=%b squashing=%b halted=%b stall=%h flush=%h, want %b %b %b %b %b %b %b %h %h",
                             $time, a.pc_en, a.ifid_en, a.ifid_flush, a.idex_flush, a.imemREN, a.squashing, a.halted,
                             a.stall_cnt, a.flush_cnt, e.pc_en, e.ifid_en, e.ifid_flush, e.idex_flush, e.imemREN,
                             e.squashing, e.halted, e.stall_cnt, e.flush_cnt);
                end
            end
        end
    end

    initial begin
        RST = 1; ihit = 0; dmem_busy = 0; load_use = 0; redirect = 0; halt = 0;
        // reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        // four hits, then a miss
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // one-cycle load-use stall, then resume
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // redirect on a miss, two more misses, then the wrong-path word returns
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // data-memory freeze beats redirect and load-use
        step(0, 1, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        // redirect accepted while squashing, then halt while squashing
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        // one-cycle reset out of HALTED
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // redirect with a hit stays in FETCH
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);

        // randomized mix of all events
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 3));
        end

        // stall counter saturation
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
